// File: rtl/cubroot_seq.sv
// rtl/cubroot_seq.sv - stream wrapper around the cubroot core
// Operand FIFO in front, single-shot launch FSM, registered result slot behind.
module cubroot_seq #(
  parameter int DEPTH  = 4,
  parameter int ACK_TO = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [7:0]       out_x_o,
  output logic [7:0]       out_y_o,
  input  logic             out_ready_i,
  output logic             cr_start_o,
  output logic [7:0]       cr_x_o,
  input  logic             cr_busy_i,
  input  logic [7:0]       cr_y_i,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TO + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [TW-1:0] ack_cnt;
  logic          push;
  logic          pop;
  logic          out_fire;
  logic          load;

  assign push     = in_valid_i && in_ready_o;
  assign pop      = (state == IDLE) && (count != '0);
  assign out_fire = out_valid_o && out_ready_i;
  assign load     = (state == WAIT_DONE) && !cr_busy_i && (!out_valid_o || out_ready_i);
  assign busy_o   = (count != '0) || (state != IDLE);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + (AW+1)'(1);
    else if (!push && pop)
      count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= in_data_i;
  end

  // in_ready is registered from the next count so a pop only reopens it a cycle later
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_o <= 1'b0;
    end else begin
      count      <= count_next;
      in_ready_o <= (count_next != (AW+1)'(DEPTH));
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cr_start_o  <= 1'b0;
      cr_x_o      <= '0;
      ack_cnt     <= '0;
      err_o       <= 1'b0;
      out_valid_o <= 1'b0;
      out_x_o     <= '0;
      out_y_o     <= '0;
      done_cnt_o  <= '0;
    end else begin
      cr_start_o <= 1'b0;
      if (out_fire)
        done_cnt_o <= done_cnt_o + CNT_W'(1);
      if (load) begin
        out_valid_o <= 1'b1;
        out_x_o     <= cr_x_o;
        out_y_o     <= cr_y_i;
      end else if (out_fire) begin
        out_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            cr_x_o     <= mem[rd_ptr];
            cr_start_o <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          ack_cnt <= '0;
          state   <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (cr_busy_i) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == TW'(ACK_TO - 1)) begin
            // core never acknowledged: flag it and drop the operand
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (load)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cubroot_seq.sv
// tb/tb_cubroot_seq.sv - scoreboard bench for cubroot_seq with a behavioural core stub
module tb_cubroot_seq;
  localparam int ACK_TO = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_x;
  logic [7:0]       out_y;
  logic             out_ready = 1'b0;
  logic             cr_start;
  logic [7:0]       cr_x;
  logic             cr_busy = 1'b0;
  logic [7:0]       cr_y = '0;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] done_cnt;

  cubroot_seq #(.DEPTH(4), .ACK_TO(ACK_TO), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .out_valid_o(out_valid), .out_x_o(out_x), .out_y_o(out_y),
    .out_ready_i(out_ready), .cr_start_o(cr_start), .cr_x_o(cr_x), .cr_busy_i(cr_busy),
    .cr_y_i(cr_y), .busy_o(busy), .err_o(err), .done_cnt_o(done_cnt)
  );

  always #5 clk = ~clk;

  // core stub: busy one cycle after start, 6 busy cycles, result held until next start
  bit       stub_dead = 1'b0;
  logic [7:0] stub_x = '0;
  int       stub_cnt = 0;

  function automatic logic [7:0] cbrt8(input logic [7:0] x);
    logic [7:0] r = 0;
    for (int i = 0; i <= 6; i++)
      if (i * i * i <= int'(x)) r = 8'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (stub_dead) begin
      cr_busy <= 1'b0;
    end else if (cr_start) begin
      cr_busy  <= 1'b1;
      stub_x   <= cr_x;
      stub_cnt <= 5;
    end else if (cr_busy) begin
      if (stub_cnt == 0) begin
        cr_busy <= 1'b0;
        cr_y    <= cbrt8(stub_x);
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int st_len = 0;
  int st_cyc = 0;
  bit err_seen = 0;
  int err_cyc = 0;
  logic [15:0] q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cr_start) begin
      if (st_len == 0) st_cyc = cyc;
      st_len++;
    end
    if (err && !err_seen) begin
      err_seen = 1;
      err_cyc  = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: every output handshake is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_i && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got x=%0d y=%0d, expected none", out_x, out_y);
      end else begin
        logic [15:0] e;
        e = q.pop_front();
        chk("out_x", 32'(out_x), 32'(e[15:8]));
        chk("out_y", 32'(out_y), 32'(e[7:0]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] x, input bit expect_out, input logic [7:0] y);
    int t = 0;
    if (expect_out) q.push_back({x, y});
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (t >= 300) chk("push_timeout", 32'(in_ready), 32'd1);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 32'(q.size()), 32'd0);
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    bit seen;
    tick(3);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_start", 32'(cr_start), 0);
    chk("rst_done", 32'(done_cnt), 0);
    rst_i = 1'b1;
    tick(1);
    chk("ready_after_release", 32'(in_ready), 1);

    // stream of distinct operands, consumer always ready
    out_ready = 1'b1;
    push(8'd27, 1, 8'd3);
    push(8'd0, 1, 8'd0);
    push(8'd255, 1, 8'd6);
    push(8'd64, 1, 8'd4);
    push(8'd8, 1, 8'd2);
    push(8'd125, 1, 8'd5);
    drain();
    chk("done_after_stream", 32'(done_cnt), 6);

    // launch timing for a single operand
    st_len = 0;
    push(8'd216, 1, 8'd6);
    tick(4);
    chk("start_len", 32'(st_len), 1);
    chk("start_delay", 32'(st_cyc - hs_cyc), 2);
    drain();
    chk("done_after_216", 32'(done_cnt), 7);

    // back-pressure: FIFO fills, FSM stalls holding the next result
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i), 1, 8'd1);
    @(negedge clk);
    chk("full_ready_low", 32'(in_ready), 0);
    tick(30);
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_x", 32'(out_x), 1);
    chk("stall_y", 32'(out_y), 1);
    chk("stall_core_idle", 32'(cr_busy), 0);
    chk("stall_busy", 32'(busy), 1);
    out_ready = 1'b1;
    drain();
    chk("done_after_bp", 32'(done_cnt), 12);

    // push held against a full FIFO while the consumer frees a slot
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i), 1, 8'd1);
    tick(20);
    chk("full_again", 32'(in_ready), 0);
    q.push_back({8'd7, 8'd1});
    in_valid  = 1'b1;
    in_data   = 8'd7;
    out_ready = 1'b1;
    lows = 0;
    seen = 0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1;
        chk("ready_with_start", 32'(cr_start), 1);
      end else begin
        lows++;
      end
    end
    chk("ready_low_cycles", 32'(lows), 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    chk("done_after_full", 32'(done_cnt), 19);

    // dead core: launch fault after the ack timeout
    stub_dead = 1'b1;
    st_len = 0;
    err_seen = 0;
    push(8'd27, 0, 8'd0);
    tick(ACK_TO + 8);
    chk("err_set", 32'(err), 1);
    chk("err_delay", 32'(err_cyc - st_cyc), ACK_TO + 1);
    chk("err_no_output", 32'(out_valid), 0);
    chk("err_idle", 32'(busy), 0);
    stub_dead = 1'b0;

    // asynchronous reset in WAIT_DONE with three operands buffered
    push(8'd10, 0, 8'd0);
    push(8'd20, 0, 8'd0);
    push(8'd30, 0, 8'd0);
    push(8'd40, 0, 8'd0);
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_start", 32'(cr_start), 0);
    chk("arst_cr_x", 32'(cr_x), 0);
    chk("arst_out_y", 32'(out_y), 0);
    chk("arst_done", 32'(done_cnt), 0);
    tick(10);
    rst_i = 1'b1;
    tick(1);
    push(8'd125, 1, 8'd5);
    drain();
    tick(10);
    chk("done_after_rst", 32'(done_cnt), 1);
    chk("idle_at_end", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cubroot_seq.md
Name: cubroot_seq

Overview:
Streaming front-end and back-end for the cubroot core.
- Accepts 8-bit operands on a valid/ready input, buffers them in a small FIFO, and launches one cubroot computation at a time through its start/busy interface.
- Captures each result and presents it, paired with its operand, on a valid/ready output.
- Sits directly around cubroot. Turns the single-shot, busy-gated core into a back-pressured stream stage.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, ≥2)
ACK_TO, 4, cycles allowed from start pulse to core busy before declaring a launch fault
CNT_W, 16, width of completed-result counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-low
in_valid_i  in  1  operand valid
in_data_i  in  8  operand x
in_ready_o  out  1  FIFO not full
out_valid_o  out  1  result valid
out_x_o  out  8  operand that produced the result
out_y_o  out  8  floor(cbrt(x))
out_ready_i  in  1  consumer accepts result
cr_start_o  out  1  start pulse to cubroot
cr_x_o  out  8  operand to cubroot, held stable from LAUNCH until next pop
cr_busy_i  in  1  cubroot busy
cr_y_i  in  8  cubroot result
busy_o  out  1  FIFO non-empty or FSM not IDLE
err_o  out  1  sticky launch fault
done_cnt_o  out  CNT_W  results delivered on output handshake, wraps

Behaviour:
Reset (rst_i low, async):
- State IDLE; FIFO empty; all outputs 0.
- in_ready_o becomes 1 on the first clock after release.

FIFO:
- Push when in_valid_i && in_ready_o.
- in_ready_o = !full (registered count, no combinational path from pop).
- Pushed entry is visible to the FSM the next cycle. No bypass.

FSM states and transitions:
- IDLE: if FIFO non-empty, pop into cr_x_o; -> LAUNCH.
- LAUNCH: cr_start_o=1 for exactly this cycle; clear ack timer; -> WAIT_ACK.
- WAIT_ACK: if cr_busy_i, -> WAIT_DONE.
  - Otherwise increment timer. At ACK_TO: set err_o, drop the operand, -> IDLE.
  - The core raises busy one cycle after start, so the nominal stay is 1 cycle.
- WAIT_DONE: when cr_busy_i=0, the result is valid on cr_y_i.
  - If out_valid_o=0, or out_ready_i=1 this cycle: load out_y_o=cr_y_i and out_x_o=cr_x_o, set out_valid_o; -> IDLE.
  - Otherwise stall here. The core holds its result until the next start, so stalling is safe.

Output slot:
- out_valid_o clears on out_valid_o && out_ready_i unless reloaded in the same cycle.
- done_cnt_o increments on each output handshake and wraps at 2^CNT_W.

General rules:
- cr_start_o is never asserted outside LAUNCH, so the core is never started while busy.
- Minimum latency, in_valid handshake to core busy: 3 cycles.
- Results leave in operand order.
- err_o clears only on reset.
- Reset mid-operation drops FIFO contents and any pending result. If the core is still busy, it is not waited for: after reset the next launch asserts start only from IDLE.

Test Plan:
- Push 27, then 0, 255, 64, 8, 125 with out_ready_i=1 -> out_y_o = 3, 0, 6, 4, 2, 5 in order; out_x_o echoes each operand; done_cnt_o=6.
- Push 1, 2, 3, 4, 5 back-to-back, out_ready_i=0 -> in_ready_o drops once 4 entries are buffered. Core finishes x=1, result 1, holds it; FSM stalls in WAIT_DONE with result 1 for x=2. Raise out_ready_i -> results 1, 1, 1, 1, 1 delivered in order, no loss.
- Single operand 216 -> cr_start_o high exactly 1 cycle, 2 cycles after the input handshake; out_y_o=6.
- Tie cr_busy_i=0 through a bench-side core stub, push 27 -> err_o rises ACK_TO+1 cycles after start; no output; FSM back in IDLE.
- Assert rst_i low while in WAIT_DONE with 3 FIFO entries -> all outputs 0 immediately, asynchronously. After release, push 125 -> result 5 only.
- Push while full and simultaneously consume -> no push accepted that cycle; in_ready_o rises the cycle after the pop.
